// File: rtl/isp_multich_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : isp_multich_pipe
//  Purpose  : NUM_CH independent RGB pixel channels sharing one strobe. Each
//             channel applies a per-frame mode (bypass, gray, horizontal
//             3-tap smooth, or binary threshold) with a fixed 2-cycle latency.
//  Ports    : clk          - single clock
//             reset        - synchronous, active-low
//             frame_start  - frame boundary pulse; latches mode_req
//             line_start   - first pixel of a line (qualified by pix_valid)
//             pix_valid    - input pixel strobe shared by all channels
//             pix_in       - packed pixels, channel k at [k*PIX_W +: PIX_W]
//             mode_req     - requested mode per channel (2 bits each)
//             thresh       - binary-mode gray threshold (PIX_W/3 bits)
//             pix_out      - processed pixels, same packing as pix_in
//             out_valid    - pix_out qualifier
//             mode_active  - mode currently applied per channel
//  Revision : 1.0 - initial release
// ============================================================================
module isp_multich_pipe #(
  parameter int NUM_CH = 4,
  parameter int PIX_W  = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    line_start,
  input  logic                    pix_valid,
  input  logic [NUM_CH*PIX_W-1:0] pix_in,
  input  logic [NUM_CH*2-1:0]     mode_req,
  input  logic [PIX_W/3-1:0]      thresh,
  output logic [NUM_CH*PIX_W-1:0] pix_out,
  output logic                    out_valid,
  output logic [NUM_CH*2-1:0]     mode_active
);

  localparam int COMP_W = PIX_W / 3;
  localparam int GW     = COMP_W + 5;  // gray weighted-sum width
  localparam int HW     = COMP_W + 2;  // smoothing sum width

  localparam logic [1:0] MODE_BYPASS  = 2'b00;
  localparam logic [1:0] MODE_GRAY    = 2'b01;
  localparam logic [1:0] MODE_HSMOOTH = 2'b10;

  logic [NUM_CH*2-1:0] mode_active_q;
  logic [NUM_CH*2-1:0] mode_eff_d;
  logic                s1_valid_q;
  logic [COMP_W-1:0]   s1_thr_q;
  logic                out_valid_q;

  // A pixel accepted together with frame_start must already see the new mode.
  assign mode_eff_d = frame_start ? mode_req : mode_active_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_active_q <= '0;
      s1_valid_q    <= 1'b0;
      s1_thr_q      <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      if (frame_start) begin
        mode_active_q <= mode_req;
      end
      s1_valid_q  <= pix_valid;
      s1_thr_q    <= thresh;
      out_valid_q <= s1_valid_q;
    end
  end

  assign out_valid   = out_valid_q;
  assign mode_active = mode_active_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PIX_W-1:0] pix_w;
    logic [PIX_W-1:0] hist1_q;     // p[x-1]
    logic [PIX_W-1:0] hist2_q;     // p[x-2]
    logic [PIX_W-1:0] tap1_d;
    logic [PIX_W-1:0] tap2_d;
    logic [PIX_W-1:0] s1_pix_q;
    logic [PIX_W-1:0] s1_tap1_q;
    logic [PIX_W-1:0] s1_tap2_q;
    logic [1:0]       s1_mode_q;
    logic [PIX_W-1:0] smooth_w;
    logic [GW-1:0]    gsum_w;
    logic [COMP_W-1:0] gray_w;
    logic             bin_w;
    logic [PIX_W-1:0] pix_d;
    logic [PIX_W-1:0] out_pix_q;

    assign pix_w = pix_in[k*PIX_W +: PIX_W];

    // Edge replicate: at line start both taps take the current pixel.
    assign tap1_d = line_start ? pix_w : hist1_q;
    assign tap2_d = line_start ? pix_w : hist2_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        hist1_q   <= '0;
        hist2_q   <= '0;
        s1_pix_q  <= '0;
        s1_tap1_q <= '0;
        s1_tap2_q <= '0;
        s1_mode_q <= MODE_BYPASS;
        out_pix_q <= '0;
      end else begin
        // History advances only on accepted pixels, whatever the mode.
        if (pix_valid) begin
          hist1_q   <= pix_w;
          hist2_q   <= tap1_d;
          s1_pix_q  <= pix_w;
          s1_tap1_q <= tap1_d;
          s1_tap2_q <= tap2_d;
          s1_mode_q <= mode_eff_d[k*2 +: 2];
        end
        out_pix_q <= s1_valid_q ? pix_d : '0;
      end
    end

    for (genvar j = 0; j < 3; j++) begin : g_comp
      logic [HW-1:0] hsum_w;
      assign hsum_w = HW'(s1_tap2_q[j*COMP_W +: COMP_W])
                    + (HW'(s1_tap1_q[j*COMP_W +: COMP_W]) << 1)
                    + HW'(s1_pix_q[j*COMP_W +: COMP_W])
                    + HW'(2);
      assign smooth_w[j*COMP_W +: COMP_W] = COMP_W'(hsum_w >> 2);
    end

    always_comb begin
      gsum_w = GW'(s1_pix_q[3*COMP_W-1 -: COMP_W]) * GW'(5)
             + GW'(s1_pix_q[2*COMP_W-1 -: COMP_W]) * GW'(9)
             + GW'(s1_pix_q[COMP_W-1:0]) * GW'(2);
      gray_w = COMP_W'(gsum_w >> 4);
      bin_w  = (gsum_w >> 4) >= GW'(s1_thr_q);
      case (s1_mode_q)
        MODE_BYPASS:  pix_d = s1_pix_q;
        MODE_GRAY:    pix_d = {gray_w, gray_w, gray_w};
        MODE_HSMOOTH: pix_d = smooth_w;
        default:      pix_d = {PIX_W{bin_w}};
      endcase
    end

    assign pix_out[k*PIX_W +: PIX_W] = out_pix_q;
  end

endmodule
`default_nettype wire

// File: doc/isp_multich_pipe.md
ISP_MULTICH_PIPE -- requirements
Module: isp_multich_pipe

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent pixel channels.
REQ-002 SHALL have parameter PIX_W, default 12, RGB pixel width; must be a multiple of 3; component width C = PIX_W/3.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse marking the frame boundary.
REQ-006 SHALL have port line_start  input  1  marks the first pixel of a line; qualified by pix_valid.
REQ-007 SHALL have port pix_valid  input  1  input pixel strobe (qvga_en); all channels share it.
REQ-008 SHALL have port pix_in  input  NUM_CH*PIX_W  packed RGB pixels; channel k at bits [k*PIX_W +: PIX_W], R in the MSBs.
REQ-009 SHALL have port mode_req  input  NUM_CH*2  requested mode per channel: 00 bypass, 01 gray, 10 hsmooth, 11 binary.
REQ-010 SHALL have port thresh  input  C  binary-mode gray threshold, shared by all channels.
REQ-011 SHALL have port pix_out  output  NUM_CH*PIX_W  processed pixels, same packing as pix_in.
REQ-012 SHALL have port out_valid  output  1  pix_out qualifier.
REQ-013 SHALL have port mode_active  output  NUM_CH*2  mode currently applied per channel.

Function
REQ-014 SHALL latch mode_req into mode_active only on cycles with frame_start=1; mode_active SHALL hold at all other times.
REQ-015 A pixel accepted in the same cycle as frame_start SHALL use the newly latched mode.
REQ-016 SHALL have a fixed latency of 2 cycles: out_valid(t+2) = pix_valid(t); pix_out(t+2) SHALL be the result for pix_in(t).
REQ-017 When out_valid=0, pix_out SHALL be all zeros.
REQ-018 Bypass: output SHALL equal the input pixel.
REQ-019 Gray: g = (5*R + 9*G + 2*B) >> 4 at C+5-bit intermediate width; output SHALL be {g,g,g}.
REQ-020 Binary: output SHALL be all ones if g >= thresh, otherwise all zeros; thresh SHALL be sampled in the cycle the pixel is accepted.
REQ-021 Hsmooth: each component SHALL be (p[x-2] + 2*p[x-1] + p[x] + 2) >> 2 at C+2-bit intermediate width; the result never exceeds 2^C-1.
REQ-022 Each channel SHALL keep a 2-deep history (p[x-1], p[x-2]) that shifts only on pix_valid=1; gaps in pix_valid SHALL NOT corrupt it.
REQ-023 For pix_valid=1 with line_start=1, both history taps SHALL be treated as equal to the current pixel (edge replicate) and then loaded with it.
REQ-024 The history SHALL update in every mode, so a mode switch at frame_start sees a valid history from the next line_start onward.
REQ-025 line_start with pix_valid=0 SHALL be ignored.
REQ-026 Channels SHALL be fully independent; one channel's mode SHALL NOT affect another channel's output.

Reset
REQ-027 With reset=0 at a rising clk edge: mode_active=0 (bypass) for all channels, history taps=0, pipeline valid bits=0, out_valid=0, pix_out=0.
REQ-028 Reset SHALL take priority over frame_start and pix_valid in the same cycle; pixels in flight SHALL be discarded.
REQ-029 After reset, channels SHALL remain in bypass until the first frame_start.

Verification
REQ-030 Reset then pix_valid=1, pix_in ch0=12'hABC, no frame_start -> 2 cycles later out_valid=1, ch0 out=12'hABC (bypass).
REQ-031 frame_start with mode_req ch1=01; ch1 in=12'hF00 -> g=(75)>>4=4, ch1 out=12'h444 two cycles later; ch0 in bypass unchanged.
REQ-032 ch2 mode 10; line_start with 12'h000, then 12'hFFF, then 12'hFFF -> ch2 R outputs 0, (0+0+15+2)>>2=4, (0+30+15+2)>>2=11 -> 12'h000, 12'h444, 12'hBBB.
REQ-033 ch3 mode 11, thresh=4; inputs 12'hF00 (g=4), then 12'h300 (g=0) -> outputs 12'hFFF, then 12'h000; change mode_req mid-frame -> mode_active unchanged until next frame_start.
REQ-034 pix_valid pattern 1,0,0,1 in hsmooth -> the 2nd output uses the 1st pixel as p[x-1]; out_valid pattern delayed by exactly 2 cycles; pix_out=0 in gap cycles.
REQ-035 Assert reset=0 mid-line with pixels in flight -> next cycle out_valid=0, pix_out=0, mode_active=0; no stale output after release.
